// File: rtl/clkdiv_scale_ctrl.sv
// clkdiv_scale_ctrl
//   Round-robin arbitrated reconfiguration controller for clock_divider.
//   A granted request with a new scale holds the divider in reset, swaps the
//   scale while the divider is in reset, releases it, then waits a settle
//   window before the next grant. Zero-scale requests are rejected and
//   same-scale requests complete without touching the divider.
//
// Ports
//   clk_in     in   system clock, rising edge
//   nrst       in   asynchronous active-low reset
//   req        in   [NREQ]        per-requester request level
//   scale_req  in   [NREQ*WIDTH]  requester i scale at [i*WIDTH +: WIDTH]
//   ack        out  [NREQ]        one-cycle completion pulse
//   err        out  [NREQ]        one-cycle rejection pulse (scale 0)
//   div_nrst   out                registered reset to clock_divider
//   div_scale  out  [WIDTH]       registered scale to clock_divider
//   busy       out                high in every state except IDLE
module clkdiv_scale_ctrl #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned NREQ        = 2,
  parameter int unsigned HOLD_CYC    = 2,
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned RESET_SCALE = 3
) (
  input  logic                  clk_in,
  input  logic                  nrst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] scale_req,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       err,
  output logic                  div_nrst,
  output logic [WIDTH-1:0]      div_scale,
  output logic                  busy
);

  localparam int unsigned CNT_MAX = (HOLD_CYC > SETTLE_CYC) ? HOLD_CYC : SETTLE_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     win_q, win_d;
  logic                 pwrup_q, pwrup_d;
  logic                 div_nrst_q, div_nrst_d;
  logic [WIDTH-1:0]     div_scale_q, div_scale_d;
  logic [NREQ-1:0]      ack_q, ack_d;
  logic [NREQ-1:0]      err_q, err_d;
  logic                 busy_q, busy_d;

  logic [WIDTH-1:0]     scale_arr [NREQ];
  logic                 found;
  logic [IDX_W-1:0]     cand;
  logic [IDX_W-1:0]     win_sel;
  logic [WIDTH-1:0]     win_scale;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign scale_arr[g] = scale_req[g*WIDTH +: WIDTH];
  end

  function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search starting one past the last winner, wrapping at NREQ
  // (NREQ need not be a power of two, so the wrap is explicit).
  always_comb begin
    found   = 1'b0;
    cand    = ptr_q;
    win_sel = ptr_q;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (cand == IDX_W'(NREQ - 1)) ? '0 : cand + IDX_W'(1);
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_sel = cand;
      end
    end
    win_scale = scale_arr[win_sel];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    pwrup_d     = pwrup_q;
    div_nrst_d  = div_nrst_q;
    div_scale_d = div_scale_q;
    ack_d       = '0;
    err_d       = '0;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          ptr_d = win_sel;
          win_d = win_sel;
          if (win_scale == '0) begin
            err_d = onehot(win_sel);
          end else if (win_scale == div_scale_q) begin
            // ack is raised on entry so it is visible during the DONE cycle
            state_d = S_DONE;
            ack_d   = onehot(win_sel);
          end else begin
            state_d     = S_HOLD;
            div_nrst_d  = 1'b0;
            div_scale_d = win_scale;
            cnt_d       = CNT_W'(HOLD_CYC - 1);
          end
        end
      end

      S_HOLD: begin
        if (cnt_q == '0) begin
          div_nrst_d = 1'b1;
          pwrup_d    = 1'b0;
          // The power-up hold has no requester: no ack and no settle window.
          if (!pwrup_q) begin
            ack_d = onehot(win_q);
          end
          if (pwrup_q || (SETTLE_CYC == 0)) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_SETTLE;
            cnt_d   = CNT_W'(SETTLE_CYC - 1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_HOLD;
      cnt_q       <= CNT_W'(HOLD_CYC - 1);
      ptr_q       <= IDX_W'(NREQ - 1);
      win_q       <= '0;
      pwrup_q     <= 1'b1;
      div_nrst_q  <= 1'b0;
      div_scale_q <= WIDTH'(RESET_SCALE);
      ack_q       <= '0;
      err_q       <= '0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      pwrup_q     <= pwrup_d;
      div_nrst_q  <= div_nrst_d;
      div_scale_q <= div_scale_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign div_nrst  = div_nrst_q;
  assign div_scale = div_scale_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_clkdiv_scale_ctrl.sv
// Directed testbench for clkdiv_scale_ctrl with default parameters
// (WIDTH=8, NREQ=2, HOLD_CYC=2, SETTLE_CYC=4, RESET_SCALE=3).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_clkdiv_scale_ctrl;

  logic        clk_in = 1'b0;
  logic        nrst;
  logic [1:0]  req;
  logic [15:0] scale_req;
  logic [1:0]  ack;
  logic [1:0]  err;
  logic        div_nrst;
  logic [7:0]  div_scale;
  logic        busy;

  int tests = 0;
  int fails = 0;

  clkdiv_scale_ctrl #(
    .WIDTH      (8),
    .NREQ       (2),
    .HOLD_CYC   (2),
    .SETTLE_CYC (4),
    .RESET_SCALE(3)
  ) dut (
    .clk_in   (clk_in),
    .nrst     (nrst),
    .req      (req),
    .scale_req(scale_req),
    .ack      (ack),
    .err      (err),
    .div_nrst (div_nrst),
    .div_scale(div_scale),
    .busy     (busy)
  );

  always #5 clk_in = ~clk_in;

  // Observed vector layout: {div_nrst, div_scale[7:0], ack[1:0], err[1:0], busy}
  task automatic test_reset();
    logic [13:0] exp;
    int first_hi;
    nrst      = 1'b0;
    req       = 2'b00;
    scale_req = '0;
    repeat (2) @(negedge clk_in);
    exp = {1'b0, 8'd3, 2'b00, 2'b00, 1'b1};
    tests++;
    if ({div_nrst, div_scale, ack, err, busy} !== exp) begin
      fails++;
      $display("FAIL reset_state: got %h expected %h", {div_nrst, div_scale, ack, err, busy}, exp);
    end
    nrst     = 1'b1;
    first_hi = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_in);
      if (div_nrst && first_hi == 0) first_hi = k;
      if (k == 1) exp = {1'b0, 8'd3, 2'b00, 2'b00, 1'b1};
      else        exp = {1'b1, 8'd3, 2'b00, 2'b00, 1'b0};
      tests++;
      if ({div_nrst, div_scale, ack, err, busy} !== exp) begin
        fails++;
        $display("FAIL powerup_cycle%0d: got %h expected %h", k, {div_nrst, div_scale, ack, err, busy}, exp);
      end
    end
    tests++;
    if (first_hi !== 2) begin
      fails++;
      $display("FAIL powerup_release_delay: got %0d expected 2", first_hi);
    end
  endtask

  // Both requesters raised in the same cycle; each drops req in its ack cycle.
  task automatic test_contention(input string name, input logic [7:0] s0, input logic [7:0] s1,
                                 input logic [1:0] exp_first, input logic [7:0] exp_sc1,
                                 input logic [7:0] exp_sc2);
    logic [1:0] ack_seen [2];
    logic [7:0] sc_seen  [2];
    int         cyc_seen [2];
    int         n;
    n = 0;
    scale_req[7:0]  = s0;
    scale_req[15:8] = s1;
    @(negedge clk_in);
    req = 2'b11;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk_in);
      if (err != 2'b00) begin
        tests++;
        fails++;
        $display("FAIL %s_err: got %b expected 00", name, err);
      end
      if (ack != 2'b00) begin
        if (n < 2) begin
          ack_seen[n] = ack;
          sc_seen[n]  = div_scale;
          cyc_seen[n] = c;
        end
        n++;
        req = req & ~ack;
      end
    end
    req = 2'b00;
    tests++;
    if (n !== 2) begin
      fails++;
      $display("FAIL %s_ack_count: got %0d expected 2", name, n);
    end else begin
      tests++;
      if (ack_seen[0] !== exp_first) begin
        fails++;
        $display("FAIL %s_first: got %b expected %b", name, ack_seen[0], exp_first);
      end
      tests++;
      if (ack_seen[1] !== ~exp_first) begin
        fails++;
        $display("FAIL %s_second: got %b expected %b", name, ack_seen[1], ~exp_first);
      end
      tests++;
      if (sc_seen[0] !== exp_sc1 || sc_seen[1] !== exp_sc2) begin
        fails++;
        $display("FAIL %s_scales: got %0d,%0d expected %0d,%0d", name, sc_seen[0], sc_seen[1], exp_sc1, exp_sc2);
      end
      tests++;
      if (cyc_seen[1] - cyc_seen[0] !== 7) begin
        fails++;
        $display("FAIL %s_gap: got %0d expected 7", name, cyc_seen[1] - cyc_seen[0]);
      end
    end
  endtask

  task automatic test_single();
    logic [13:0] exp;
    scale_req[7:0] = 8'd6;
    req = 2'b01;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk_in);
      exp = {(i >= 3), 8'd6, (i == 3) ? 2'b01 : 2'b00, 2'b00, (i <= 6)};
      tests++;
      if ({div_nrst, div_scale, ack, err, busy} !== exp) begin
        fails++;
        $display("FAIL single_cycle%0d: got %h expected %h", i, {div_nrst, div_scale, ack, err, busy}, exp);
      end
      if (i == 3) req = 2'b00;
    end
  endtask

  // Current scale is 4 on entry.
  task automatic test_zero_same();
    logic [13:0] exp;
    scale_req[15:8] = 8'd0;
    req = 2'b10;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk_in);
      exp = {1'b1, 8'd4, 2'b00, (i == 1) ? 2'b10 : 2'b00, 1'b0};
      tests++;
      if ({div_nrst, div_scale, ack, err, busy} !== exp) begin
        fails++;
        $display("FAIL zero_cycle%0d: got %h expected %h", i, {div_nrst, div_scale, ack, err, busy}, exp);
      end
      req = 2'b00;
    end
    scale_req[7:0] = 8'd4;
    req = 2'b01;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk_in);
      exp = {1'b1, 8'd4, (i == 1) ? 2'b01 : 2'b00, 2'b00, (i == 1)};
      tests++;
      if ({div_nrst, div_scale, ack, err, busy} !== exp) begin
        fails++;
        $display("FAIL same_cycle%0d: got %h expected %h", i, {div_nrst, div_scale, ack, err, busy}, exp);
      end
      req = 2'b00;
    end
  endtask

  task automatic test_withdraw();
    logic [13:0] exp;
    scale_req[7:0] = 8'd8;
    req = 2'b01;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk_in);
      exp = {(i >= 3), 8'd8, (i == 3) ? 2'b01 : 2'b00, 2'b00, (i <= 6)};
      tests++;
      if ({div_nrst, div_scale, ack, err, busy} !== exp) begin
        fails++;
        $display("FAIL withdraw_cycle%0d: got %h expected %h", i, {div_nrst, div_scale, ack, err, busy}, exp);
      end
      if (i == 1) begin
        req            = 2'b00;
        scale_req[7:0] = 8'd2;
      end
    end
  endtask

  task automatic test_midreset();
    logic [13:0] exp;
    int ack_cnt;
    ack_cnt = 0;
    scale_req[7:0] = 8'd9;
    req = 2'b01;
    @(negedge clk_in);
    exp = {1'b0, 8'd9, 2'b00, 2'b00, 1'b1};
    tests++;
    if ({div_nrst, div_scale, ack, err, busy} !== exp) begin
      fails++;
      $display("FAIL midreset_hold: got %h expected %h", {div_nrst, div_scale, ack, err, busy}, exp);
    end
    nrst = 1'b0;
    req  = 2'b00;
    #1;
    exp = {1'b0, 8'd3, 2'b00, 2'b00, 1'b1};
    tests++;
    if ({div_nrst, div_scale, ack, err, busy} !== exp) begin
      fails++;
      $display("FAIL midreset_async: got %h expected %h", {div_nrst, div_scale, ack, err, busy}, exp);
    end
    @(negedge clk_in);
    nrst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_in);
      if (ack != 2'b00) ack_cnt++;
      if (k <= 3) begin
        exp = (k == 1) ? {1'b0, 8'd3, 2'b00, 2'b00, 1'b1} : {1'b1, 8'd3, 2'b00, 2'b00, 1'b0};
        tests++;
        if ({div_nrst, div_scale, ack, err, busy} !== exp) begin
          fails++;
          $display("FAIL midreset_release%0d: got %h expected %h", k, {div_nrst, div_scale, ack, err, busy}, exp);
        end
      end
    end
    tests++;
    if (ack_cnt !== 0) begin
      fails++;
      $display("FAIL midreset_no_ack: got %0d acks expected 0", ack_cnt);
    end
  endtask

  initial begin
    test_reset();
    // pointer starts at NREQ-1, so requester 0 wins first
    test_contention("contention_a", 8'd5, 8'd7, 2'b01, 8'd5, 8'd7);
    // last winner becomes requester 0
    test_single();
    test_contention("contention_b", 8'd4, 8'd9, 2'b10, 8'd9, 8'd4);
    test_zero_same();
    test_withdraw();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
